// File: rtl/data_memory_ws_if.sv
// Request/response bundle between the MEM stage and data_memory_ws.
// byteEn only exists when DMEM_BYTE_LANES_EN is defined.
interface data_memory_ws_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] data;
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]  byteEn;
`endif
  logic [31:0] memOut;
  logic        ready;
  logic        memErr;
  logic        busy;

  modport master (
    output memRead, memWrite, address, data,
`ifdef DMEM_BYTE_LANES_EN
    output byteEn,
`endif
    input  memOut, ready, memErr, busy
  );

  modport slave (
    input  memRead, memWrite, address, data,
`ifdef DMEM_BYTE_LANES_EN
    input  byteEn,
`endif
    output memOut, ready, memErr, busy
  );
endinterface

// File: rtl/data_memory_ws.sv
// Wait-state data memory for the MEM stage; fixed latency, one-cycle ready.
// Optional per-byte write lanes with DMEM_BYTE_LANES_EN.
module data_memory_ws #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  data_memory_ws_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_W = 30'(BASE_ADDR >> 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] out_q, out_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [3:0]  wr_be;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   off;
  logic          in_win;
  logic [AW-1:0] idx;
  logic          mem_we;
  logic          unused_addr;

  assign unused_addr = ^bus.address[1:0];

  // Word-granular window check; the >= test stops low addresses aliasing.
  assign off    = addr_q - BASE_W;
  assign in_win = (addr_q >= BASE_W) && ((off >> AW) == '0);
  assign idx    = off[AW-1:0];
  assign mem_we = (state_q == BUSY) && (cnt_q == '0)
                  && wr_q && in_win;

`ifdef DMEM_BYTE_LANES_EN
  logic [3:0] be_q, be_d;

  always_comb begin
    be_d = be_q;
    if (state_q == IDLE && (bus.memRead | bus.memWrite))
      be_d = bus.byteEn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) be_q <= '0;
    else     be_q <= be_d;
  end

  assign wr_be = be_q;
`else
  assign wr_be = 4'hF;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.memRead | bus.memWrite) begin
          wr_d    = bus.memWrite;
          rd_d    = bus.memRead & ~bus.memWrite;
          addr_d  = bus.address[31:2];
          data_d  = bus.data;
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          err_d   = ~in_win;
          state_d = DONE;
          if (rd_q)
            out_d = in_win ? mem[idx] : '0;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b])
          mem[idx][8*b +: 8] <= data_q[8*b +: 8];
    end
  end

  assign bus.memOut = out_q;
  assign bus.ready  = ready_q;
  assign bus.memErr = err_q;
  assign bus.busy   = busy_q;
endmodule
